// File: rtl/al4s3b_wb_initiator_if.sv
// Wishbone register-bus signal bundle shared by the initiator and its responder.
// Signal names follow the fabric register IP's WBs_* naming.
interface al4s3b_wb_initiator_if #(
  parameter int unsigned APERWIDTH = 17,
  parameter int unsigned DATAWIDTH = 32
);
  localparam int unsigned StbW = DATAWIDTH / 8;

  logic [APERWIDTH-1:0] WBs_ADR;
  logic                 WBs_CYC;
  logic                 WBs_STB;
  logic                 WBs_WE;
  logic                 WBs_RD;
  logic [StbW-1:0]      WBs_BYTE_STB;
  logic [DATAWIDTH-1:0] WBs_WR_DAT;
  logic [DATAWIDTH-1:0] WBs_RD_DAT;
  logic                 WBs_ACK;

  modport master (
    output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
    input  WBs_RD_DAT, WBs_ACK
  );

  modport slave (
    input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
    output WBs_RD_DAT, WBs_ACK
  );
endinterface

// File: rtl/al4s3b_wb_initiator.sv
// Single-outstanding Wishbone initiator: command/response stream to WBs_* bus cycles.
// Define AL4S3B_WB_INITIATOR_TIMEOUT_EN to compile in the no-ACK watchdog.
module al4s3b_wb_initiator #(
  parameter int unsigned          APERWIDTH          = 17,
  parameter int unsigned          DATAWIDTH          = 32,
  parameter int unsigned          TIMEOUT_CYCLES     = 16,
  parameter int unsigned          TIMEOUT_WIDTH      = 5,
  parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
  input  logic                     WB_CLK,
  input  logic                     WB_RST,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [APERWIDTH-1:0]     cmd_adr,
  input  logic [DATAWIDTH/8-1:0]   cmd_byte_stb,
  input  logic [DATAWIDTH-1:0]     cmd_wr_dat,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATAWIDTH-1:0]     rsp_rd_dat,
  output logic                     rsp_err,
  output logic                     busy,
  al4s3b_wb_initiator_if.master    wb
);

  localparam int unsigned StbW = DATAWIDTH / 8;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e               state_q, state_d;
  logic [APERWIDTH-1:0] adr_q, adr_d;
  logic [DATAWIDTH-1:0] wr_dat_q, wr_dat_d;
  logic [StbW-1:0]      byte_stb_q, byte_stb_d;
  logic                 cyc_q, cyc_d;
  logic                 wb_we_q, wb_we_d;
  logic                 wb_rd_q, wb_rd_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_rd_dat_q, rsp_rd_dat_d;
  logic                 busy_q, busy_d;
`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
  logic                     rsp_err_q, rsp_err_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    wr_dat_d     = wr_dat_q;
    byte_stb_d   = byte_stb_q;
    cyc_d        = cyc_q;
    wb_we_d      = wb_we_q;
    wb_rd_d      = wb_rd_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rd_dat_d = rsp_rd_dat_q;
    busy_d       = busy_q;
`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d     = StBus;
          adr_d       = cmd_adr;
          wr_dat_d    = cmd_wr_dat;
          byte_stb_d  = cmd_we ? cmd_byte_stb : {StbW{1'b1}};
          cyc_d       = 1'b1;
          wb_we_d     = cmd_we;
          wb_rd_d     = ~cmd_we;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      StBus: begin
        if (wb.WBs_ACK) begin
          state_d      = StResp;
          cyc_d        = 1'b0;
          wb_we_d      = 1'b0;
          wb_rd_d      = 1'b0;
          byte_stb_d   = '0;
          rsp_valid_d  = 1'b1;
          rsp_rd_dat_d = wb_we_q ? '0 : wb.WBs_RD_DAT;
`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
          rsp_err_d    = 1'b0;
        end else if (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          // Last allowed BUS cycle passed without ACK: abort the cycle.
          state_d      = StResp;
          cyc_d        = 1'b0;
          wb_we_d      = 1'b0;
          wb_rd_d      = 1'b0;
          byte_stb_d   = '0;
          rsp_valid_d  = 1'b1;
          rsp_rd_dat_d = DEFAULT_READ_VALUE;
          rsp_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        cyc_d       = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = 1'b0;
        byte_stb_d  = '0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q      <= StIdle;
      adr_q        <= '0;
      wr_dat_q     <= '0;
      byte_stb_q   <= '0;
      cyc_q        <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rd_dat_q <= '0;
      busy_q       <= 1'b0;
`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      wr_dat_q     <= wr_dat_d;
      byte_stb_q   <= byte_stb_d;
      cyc_q        <= cyc_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rd_dat_q <= rsp_rd_dat_d;
      busy_q       <= busy_d;
`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rd_dat      = rsp_rd_dat_q;
  assign busy            = busy_q;
`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
  assign rsp_err         = rsp_err_q;
`else
  assign rsp_err         = 1'b0;
`endif

  assign wb.WBs_ADR      = adr_q;
  assign wb.WBs_WR_DAT   = wr_dat_q;
  assign wb.WBs_BYTE_STB = byte_stb_q;
  assign wb.WBs_CYC      = cyc_q;
  assign wb.WBs_STB      = cyc_q;
  assign wb.WBs_WE       = wb_we_q;
  assign wb.WBs_RD       = wb_rd_q;

endmodule

// File: tb/tb_al4s3b_wb_initiator.sv
// Self-checking bench for al4s3b_wb_initiator: vector table plus directed corner sequences.
// Watchdog sequences follow AL4S3B_WB_INITIATOR_TIMEOUT_EN, same as the design.
module tb_al4s3b_wb_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [16:0] cmd_adr;
  logic [3:0]  cmd_byte_stb;
  logic [31:0] cmd_wr_dat;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rd_dat;

  int errors = 0;
  int checks = 0;

  al4s3b_wb_initiator_if #(.APERWIDTH(17), .DATAWIDTH(32)) wb ();

  al4s3b_wb_initiator #(
    .APERWIDTH(17), .DATAWIDTH(32), .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5),
    .DEFAULT_READ_VALUE(32'hBADFABAC)
  ) dut (
    .WB_CLK(clk), .WB_RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_byte_stb(cmd_byte_stb), .cmd_wr_dat(cmd_wr_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_dat(rsp_rd_dat), .rsp_err(rsp_err),
    .busy(busy), .wb(wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [16:0] adr;
    logic [3:0]  stb;
    logic [31:0] wdat;
    int          waits;
    logic [31:0] ack_dat;
    logic [31:0] exp_rdat;
    logic [3:0]  exp_stb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic send_cmd(input logic we, input logic [16:0] adr, input logic [3:0] stb,
                          input logic [31:0] dat);
    cmd_we = we; cmd_adr = adr; cmd_byte_stb = stb; cmd_wr_dat = dat;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Acts as the responder while CYC is high; ack_after<0 means never ACK.
  task automatic drive_bus(input int ack_after, input logic [31:0] rdat, input int budget,
                           output int n, output logic we_s, output logic rd_s,
                           output logic [3:0] stb_s, output logic [16:0] adr_s,
                           output logic [31:0] wdat_s);
    n = 0;
    we_s = wb.WBs_WE; rd_s = wb.WBs_RD; stb_s = wb.WBs_BYTE_STB;
    adr_s = wb.WBs_ADR; wdat_s = wb.WBs_WR_DAT;
    while (wb.WBs_CYC && n < budget) begin
      n++;
      if (wb.WBs_STB !== 1'b1) chk("stb_with_cyc", {31'd0, wb.WBs_STB}, 32'd1);
      wb.WBs_ACK    = (n == ack_after + 1);
      wb.WBs_RD_DAT = rdat;
      @(negedge clk);
    end
    wb.WBs_ACK = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input int i);
    int n;
    logic we_s, rd_s;
    logic [3:0] stb_s;
    logic [16:0] adr_s;
    logic [31:0] wdat_s;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send_cmd(vecs[i].we, vecs[i].adr, vecs[i].stb, vecs[i].wdat);
    chk("cmd_ready_in_bus", {31'd0, cmd_ready}, 32'd0);
    drive_bus(vecs[i].waits, vecs[i].ack_dat, 50, n, we_s, rd_s, stb_s, adr_s, wdat_s);
    chk("cyc_cycles", n, vecs[i].waits + 1);
    chk("bus_we", {31'd0, we_s}, {31'd0, vecs[i].we});
    chk("bus_rd", {31'd0, rd_s}, {31'd0, ~vecs[i].we});
    chk("bus_stb", {28'd0, stb_s}, {28'd0, vecs[i].exp_stb});
    chk("bus_adr", {15'd0, adr_s}, {15'd0, vecs[i].adr});
    chk("bus_wdat", wdat_s, vecs[i].wdat);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_rd_dat", rsp_rd_dat, vecs[i].exp_rdat);
    chk("rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("we_off_after_bus", {31'd0, wb.WBs_WE | wb.WBs_RD}, 32'd0);
    chk("stb_off_after_bus", {28'd0, wb.WBs_BYTE_STB}, 32'd0);
    chk("adr_held", {15'd0, wb.WBs_ADR}, {15'd0, vecs[i].adr});
    take_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic we_s, rd_s;
    logic [3:0] stb_s;
    logic [16:0] adr_s;
    logic [31:0] wdat_s;

    vecs[0] = '{1'b1, 17'h00008, 4'h3, 32'h1234_5678, 0, 32'hDEAD_BEEF, 32'h0, 4'h3};
    vecs[1] = '{1'b0, 17'h00014, 4'h0, 32'h0000_0000, 3, 32'hCAFE_0005, 32'hCAFE_0005, 4'hF};
    vecs[2] = '{1'b0, 17'h1FFFF, 4'h5, 32'h5555_AAAA, 0, 32'h0000_0001, 32'h0000_0001, 4'hF};
    vecs[3] = '{1'b1, 17'h00000, 4'hF, 32'hFFFF_FFFF, 2, 32'h1111_2222, 32'h0, 4'hF};
    vecs[4] = '{1'b0, 17'h0ABCD, 4'h9, 32'h0F0F_0F0F, 1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 4'hF};

    // Reset with a command offered: it must not be taken.
    rst = 1'b1; rsp_ready = 1'b0;
    wb.WBs_ACK = 1'b0; wb.WBs_RD_DAT = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 17'h1_2345;
    cmd_byte_stb = 4'hF; cmd_wr_dat = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rd_dat", rsp_rd_dat, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_cyc", {30'd0, wb.WBs_CYC, wb.WBs_STB}, 32'd0);
    chk("rst_we_rd", {30'd0, wb.WBs_WE, wb.WBs_RD}, 32'd0);
    chk("rst_adr", {15'd0, wb.WBs_ADR}, 32'd0);
    chk("rst_bstb", {28'd0, wb.WBs_BYTE_STB}, 32'd0);
    chk("rst_wdat", wb.WBs_WR_DAT, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_cmd_dropped", {31'd0, wb.WBs_CYC}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Response back-pressure with a command waiting.
    send_cmd(1'b0, 17'h00030, 4'h0, 32'h0);
    drive_bus(0, 32'h7777_0001, 50, n, we_s, rd_s, stb_s, adr_s, wdat_s);
    cmd_we = 1'b1; cmd_adr = 17'h00040; cmd_byte_stb = 4'h1; cmd_wr_dat = 32'h0000_00AB;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_rd_dat", rsp_rd_dat, 32'h7777_0001);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("hold_no_cyc", {31'd0, wb.WBs_CYC}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_rsp_done", {31'd0, rsp_valid}, 32'd0);
    chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_not_yet_taken", {31'd0, wb.WBs_CYC}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_pending_taken", {31'd0, wb.WBs_CYC}, 32'd1);
    chk("bp_pending_we", {31'd0, wb.WBs_WE}, 32'd1);
    chk("bp_pending_adr", {15'd0, wb.WBs_ADR}, 32'h40);
    drive_bus(0, 32'hFFFF_FFFF, 50, n, we_s, rd_s, stb_s, adr_s, wdat_s);
    chk("bp_write_rdat", rsp_rd_dat, 32'd0);
    take_rsp();

    // Reset in the second BUS cycle of a read.
    send_cmd(1'b0, 17'h00020, 4'h0, 32'h0);
    chk("mid_cyc1", {31'd0, wb.WBs_CYC}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cyc", {31'd0, wb.WBs_CYC}, 32'd0);
    chk("mid_rst_rd", {31'd0, wb.WBs_RD}, 32'd0);
    chk("mid_rst_adr", {15'd0, wb.WBs_ADR}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    run_vec(1);

`ifdef AL4S3B_WB_INITIATOR_TIMEOUT_EN
    send_cmd(1'b0, 17'h00050, 4'h0, 32'h0);
    drive_bus(-1, 32'h0, 200, n, we_s, rd_s, stb_s, adr_s, wdat_s);
    chk("to_cyc_cycles", n, 16);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rd_dat", rsp_rd_dat, 32'hBADFABAC);
    take_rsp();
    send_cmd(1'b0, 17'h00054, 4'h0, 32'h0);
    drive_bus(15, 32'h1357_9BDF, 200, n, we_s, rd_s, stb_s, adr_s, wdat_s);
    chk("edge_cyc_cycles", n, 16);
    chk("edge_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("edge_rsp_rd_dat", rsp_rd_dat, 32'h1357_9BDF);
    take_rsp();
    run_vec(4);
`else
    send_cmd(1'b0, 17'h00050, 4'h0, 32'h0);
    drive_bus(-1, 32'h0, 100, n, we_s, rd_s, stb_s, adr_s, wdat_s);
    chk("noto_cyc_cycles", n, 100);
    chk("noto_still_cyc", {31'd0, wb.WBs_CYC}, 32'd1);
    chk("noto_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_vec(4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/al4s3b_wb_initiator.md
# al4s3b_wb_initiator

Single-outstanding Wishbone initiator that converts a command/response stream into `WBs_*` bus cycles. It is the initiator end of the fabric register bus and drives the same `WBs_*` signal set that the register IP responds to. It serves as a fabric-side bus master for self-test, DMA-style register sequencing and bench stimulus. An optional watchdog aborts cycles that are never acknowledged.

## Interface
Parameters:
- `APERWIDTH`, 17, address width.
- `DATAWIDTH`, 32, data width; byte strobes are `DATAWIDTH/8`.
- `TIMEOUT_CYCLES`, 16, bus cycles without `WBs_ACK` before abort. Legal range is 1..2^`TIMEOUT_WIDTH`-1.
- `TIMEOUT_WIDTH`, 5, watchdog counter width.
- `DEFAULT_READ_VALUE`, 32'hBAD_FAB_AC, `rsp_rd_dat` returned on timeout.

Ports:
- `WB_CLK`  in  1  sole clock; all logic rising-edge.
- `WB_RST`  in  1  reset; synchronous and active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  APERWIDTH  target address.
- `cmd_byte_stb`  in  4  write byte enables.
- `cmd_wr_dat`  in  DATAWIDTH  write data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`.
- `rsp_rd_dat`  out  DATAWIDTH  read data. Zero for writes; `DEFAULT_READ_VALUE` on timeout.
- `rsp_err`  out  1  cycle aborted by the watchdog.
- `WBs_ADR`  out  APERWIDTH  bus address.
- `WBs_CYC`, `WBs_STB`  out  1 each  cycle and strobe, always asserted together.
- `WBs_WE`  out  1  write enable.
- `WBs_RD`  out  1  read enable.
- `WBs_BYTE_STB`  out  4  byte enables.
- `WBs_WR_DAT`  out  DATAWIDTH  write data.
- `WBs_RD_DAT`  in  DATAWIDTH  read data from the responder.
- `WBs_ACK`  in  1  responder acknowledge.
- `busy`  out  1  high in states BUS and RESP.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_*` and go to BUS.
  - BUS: `WBs_CYC`=`WBs_STB`=1. `WBs_WE`=we and `WBs_RD`=~we. `WBs_ADR`, `WBs_WR_DAT` and `WBs_BYTE_STB` hold the latched values; `WBs_BYTE_STB` is 4'hF for reads.
    - `WBs_ACK`=1: capture `WBs_RD_DAT` for a read (or 0 for a write), set `rsp_err`=0, go to RESP.
  - RESP: `rsp_valid`=1 and the response fields are stable. On `rsp_ready`, go to IDLE.
- All `WBs_*`, `cmd_ready`, `rsp_*` and `busy` outputs are registered or decoded directly from state. There is no combinational path from `WBs_ACK` to any output.
- `WBs_WR_DAT` and `WBs_ADR` hold their last values outside BUS. `WBs_WE`, `WBs_RD` and `WBs_BYTE_STB` are 0 outside BUS.
- Only one transaction is outstanding. `cmd_ready`=0 in BUS and RESP.
- `WBs_ACK` is ignored outside BUS.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rd_dat`=0.
  - `WBs_CYC`=`WBs_STB`=`WBs_WE`=`WBs_RD`=0.
  - `WBs_ADR`=0, `WBs_BYTE_STB`=0, `WBs_WR_DAT`=0.
  - `busy`=0.
  - Watchdog count 0.
- Command accepted at edge N: `WBs_CYC`/`WBs_STB` are high from N+1.
- `WBs_ACK` sampled high at edge M: `WBs_CYC`/`WBs_STB` are low and `rsp_valid` is high from M+1.
- Zero-wait responder: `WBs_CYC` is high for exactly one cycle.
- Response accepted at edge K: `cmd_ready` is high from K+1. Best-case throughput is one transaction per 3 cycles.
- `rsp_ready` held high continuously: RESP lasts exactly 1 cycle.
- `WB_RST` during any state: IDLE with reset values at the next edge. The bus cycle is dropped without a response. A command presented in the reset cycle is not accepted.

## Configuration
- `AL4S3B_WB_INITIATOR_TIMEOUT_EN` defined: the watchdog is compiled in.
  - The counter clears on entry to BUS and increments every BUS cycle without ACK.
  - When the counter reaches `TIMEOUT_CYCLES` with no ACK at that edge, drop `CYC`/`STB` and go to RESP with `rsp_err`=1 and `rsp_rd_dat`=`DEFAULT_READ_VALUE`.
  - ACK on the same edge as expiry wins: normal response, `rsp_err`=0.
- Macro not defined: no counter. BUS waits indefinitely for ACK, and `rsp_err` is tied to 0.

## Test plan
- Write to addr 17'h00008 with data 32'h1234_5678 and byte_stb 4'h3, responder ACKs in the first BUS cycle. Expect:
  - `WBs_CYC` high 1 cycle with `WBs_WE`=1 and `WBs_BYTE_STB`=4'h3.
  - `rsp_valid` next cycle with `rsp_rd_dat`=0 and `rsp_err`=0.
- Read from 17'h00014, responder inserts 3 wait states and returns 32'hCAFE_0005. Expect:
  - `WBs_CYC` high 4 cycles with `WBs_RD`=1 and `WBs_BYTE_STB`=4'hF.
  - `rsp_rd_dat`=32'hCAFE_0005.
- Timeout build, `TIMEOUT_CYCLES`=16, responder never ACKs. Expect:
  - `WBs_CYC` high exactly 16 cycles.
  - `rsp_err`=1 and `rsp_rd_dat`=32'hBAD_FAB_AC.
  - Non-timeout build with the same stimulus: `WBs_CYC` stays high for 100 cycles.
- Timeout build with ACK asserted exactly on the expiry edge. Expect `rsp_err`=0 and the captured read data returned.
- `rsp_ready` held low for 5 cycles after a read. Expect:
  - `rsp_valid` and `rsp_rd_dat` stable throughout.
  - `cmd_ready`=0 throughout; a pending `cmd_valid` is not accepted until the edge after `rsp_ready`.
- Assert `WB_RST` for 1 cycle in the 2nd BUS cycle of a read. Expect:
  - All outputs at reset values on the next cycle and no `rsp_valid`.
  - A subsequent read completes normally.
